// File: rtl/parity_serializer.sv
// Parallel-to-serial framer: DATA_W data bits LSB first, then one parity bit.
// A new word can be accepted in the parity cycle so that frames run back-to-back.
module parity_serializer #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              x,
    output logic              x_valid,
    output logic              par_bit
);

    localparam int unsigned     CntW    = $clog2(DATA_W + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(DATA_W - 1);
    localparam logic            OddBit  = (PARITY_ODD != 0);

    // The state names the kind of bit currently shown on x.
    typedef enum logic [1:0] {
        StIdle,
        StData,
        StPar
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              acc_q, acc_d;
    logic              x_q, x_d;
    logic              x_valid_q, x_valid_d;
    logic              par_bit_q, par_bit_d;
    logic              xfer;

    assign din_ready = (state_q != StData);
    assign xfer      = din_valid & din_ready;

    assign x       = x_q;
    assign x_valid = x_valid_q;
    assign par_bit = par_bit_q;

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        x_d       = 1'b0;
        x_valid_d = 1'b0;
        par_bit_d = 1'b0;

        unique case (state_q)
            StIdle, StPar: begin
                if (xfer) begin
                    state_d   = StData;
                    shift_d   = din;
                    cnt_d     = '0;
                    acc_d     = 1'b0;
                    x_d       = din[0];
                    x_valid_d = 1'b1;
                end else begin
                    state_d = StIdle;
                end
            end
            StData: begin
                // shift_q[0] always mirrors the data bit on x in this state.
                acc_d     = acc_q ^ shift_q[0];
                x_valid_d = 1'b1;
                if (cnt_q == LastCnt) begin
                    state_d   = StPar;
                    x_d       = acc_q ^ shift_q[0] ^ OddBit;
                    par_bit_d = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CntW'(1);
                    shift_d = {1'b0, shift_q[DATA_W-1:1]};
                    x_d     = shift_q[1];
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            shift_q   <= '0;
            cnt_q     <= '0;
            acc_q     <= 1'b0;
            x_q       <= 1'b0;
            x_valid_q <= 1'b0;
            par_bit_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            x_q       <= x_d;
            x_valid_q <= x_valid_d;
            par_bit_q <= par_bit_d;
        end
    end

endmodule

// File: doc/parity_serializer.md
PARITY_SERIALIZER -- requirements
Module: parity_serializer

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, giving the data word width in bits (legal range 2..32).
REQ-002 The block SHALL have parameter PARITY_ODD, default 0, where 0 selects even parity and 1 selects odd parity.
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port din  input  DATA_W  parallel word to serialize.
REQ-006 The block SHALL have port din_valid  input  1  din holds a word offered for transfer.
REQ-007 The block SHALL have port din_ready  output  1  block can accept a word this cycle.
REQ-008 The block SHALL have port x  output  1  serial bit stream that feeds the downstream parity checker.
REQ-009 The block SHALL have port x_valid  output  1  x carries a frame bit this cycle.
REQ-010 The block SHALL have port par_bit  output  1  high while x carries the frame's parity bit.

Function
REQ-011 A transfer SHALL occur on a rising clk edge where din_valid and din_ready are both 1, and din SHALL be captured into an internal shift register on that edge.
REQ-012 The FSM SHALL have exactly three states: IDLE, DATA and PAR.
REQ-013 IDLE SHALL go to DATA on a transfer and SHALL otherwise stay in IDLE.
REQ-014 DATA SHALL go to PAR after DATA_W bit cycles.
REQ-015 PAR SHALL go to DATA on a transfer (back-to-back frames) and SHALL otherwise go to IDLE.
REQ-016 din_ready SHALL be 1 in IDLE and in PAR, and 0 in DATA; din_ready SHALL be a function of the state only, not of din_valid.
REQ-017 The frame SHALL be DATA_W data bits, LSB first, followed by one parity bit, for exactly DATA_W+1 consecutive x_valid cycles.
REQ-018 The first data bit SHALL appear on x in the cycle after the transfer edge, giving a latency of 1 clock.
REQ-019 x, x_valid and par_bit SHALL be registered outputs.
REQ-020 The parity bit SHALL be the XOR of all DATA_W captured bits, XORed with PARITY_ODD.
REQ-021 With even parity, the total number of ones over data plus parity SHALL be even; with odd parity, it SHALL be odd.
REQ-022 Parity SHALL be accumulated serially from the bits driven during DATA, with the accumulator cleared on each transfer.
REQ-023 The bit counter SHALL be $clog2(DATA_W+1) bits wide and SHALL be cleared on each transfer.
REQ-024 The bit counter SHALL not wrap within a frame.
REQ-025 par_bit SHALL be 1 only in the parity-bit cycle, and x_valid SHALL also be 1 in that cycle.
REQ-026 When not in a frame bit cycle, x, x_valid and par_bit SHALL all be 0.
REQ-027 Back-to-back frames SHALL have no gap: the first data bit of frame N+1 SHALL follow the parity bit of frame N in the very next cycle.
REQ-028 When din_ready is 0, din and din_valid SHALL be ignored, and a word held valid SHALL be accepted at the next ready cycle.
REQ-029 din changes while the block is in DATA SHALL NOT affect the frame in progress.

Reset
REQ-030 While rst_n is 0, the block SHALL force state IDLE, counter 0, shift register 0, parity accumulator 0, x=0, x_valid=0, par_bit=0 and din_ready=1 (din_ready=1 follows from the IDLE state).
REQ-031 Reset asserted mid-frame SHALL abort the frame immediately (asynchronously) with no further frame bits emitted and no parity bit emitted.
REQ-032 After rst_n is released, the first transfer SHALL be accepted on the first rising edge where din_valid is 1.

Verification
REQ-033 Reset check: assert rst_n=0 mid-frame -> x_valid=0, par_bit=0 and din_ready=1 within the same cycle, with no residual bits after release.
REQ-034 Even parity: DATA_W=8, PARITY_ODD=0, din=8'hA5 -> x = 1,0,1,0,0,1,0,1 then parity 0, with par_bit high on the 9th bit only.
REQ-035 Odd-count word: din=8'h07, even parity -> data bits 1,1,1,0,0,0,0,0 then parity 1.
REQ-036 Odd parity: PARITY_ODD=1, din=8'h00 -> eight 0 data bits then parity 1; din=8'hFF -> parity 1.
REQ-037 Back-to-back: din_valid held high with 8'h3C then 8'hC3 -> 18 consecutive x_valid cycles with no gap, and din_ready=1 only in the parity cycles plus the initial IDLE cycle.
REQ-038 Round trip: feed x/x_valid into the downstream parity checker over 1000 random words -> the checker's parity state returns to Even (z=0) after every frame when PARITY_ODD=0.
